// File: rtl/ptr_fetch_pkg.sv
// Shared types and width helpers for the ptr_fetch pointer-struct responder.
package ptr_fetch_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b11,
    ST_HOLD = 2'b10
  } state_e;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_COEF_AW = 10;
  localparam int unsigned DEF_PHASES  = 4;
  localparam int unsigned DEF_TAPS    = 16;
  localparam int unsigned DEF_CRED_W  = 4;

  // Phase index width; at least one bit
  function automatic int unsigned phase_w(input int unsigned phases);
    return (phases < 2) ? 1 : $clog2(phases);
  endfunction

endpackage

// File: rtl/ptr_fetch_if.sv
// Request/response bundle between controller/sample writer and ptr_fetch.
interface ptr_fetch_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned COEF_AW = 10,
  parameter int unsigned PHASE_W = 2
);
  logic               ptrs_req;
  logic               new_in;
  logic               req_complete;
  logic               iw_valid;
  logic [ADDR_W-1:0]  smp_base;
  logic [COEF_AW-1:0] coef_base;
  logic [PHASE_W-1:0] phase;
  logic               last_phase;
  logic               ovf;

  modport master (
    output ptrs_req, new_in,
    input  req_complete, iw_valid, smp_base, coef_base, phase, last_phase, ovf
  );

  modport slave (
    input  ptrs_req, new_in,
    output req_complete, iw_valid, smp_base, coef_base, phase, last_phase, ovf
  );
endinterface

// File: rtl/ptr_credit_cnt.sv
// Credit counter of written-but-unconsumed input samples.
// PTR_FETCH_OVF_DET_EN defined: saturating count with sticky overflow flag.
// PTR_FETCH_OVF_DET_EN undefined: count wraps, overflow flag tied low.
module ptr_credit_cnt #(
  parameter int unsigned CRED_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [CRED_W-1:0] cnt_o,
  output logic              zero_o,
  output logic              ovf_o
);

  logic [CRED_W-1:0] cnt_q;

`ifdef PTR_FETCH_OVF_DET_EN
  localparam logic [CRED_W-1:0] CNT_MAX = '1;
  logic ovf_q;

  // Saturating count; an unmatched increment at the ceiling flags overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      if (inc_i && !dec_i) begin
        if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
        else                  cnt_q <= cnt_q + CRED_W'(1);
      end else if (dec_i && !inc_i) begin
        cnt_q <= cnt_q - CRED_W'(1);
      end
    end
  end

  assign ovf_o = ovf_q;
`else
  // Wrapping count; simultaneous inc and dec cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (inc_i && !dec_i)      cnt_q <= cnt_q + CRED_W'(1);
      else if (dec_i && !inc_i) cnt_q <= cnt_q - CRED_W'(1);
    end
  end

  assign ovf_o = 1'b0;
`endif

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ptr_fetch.sv
// ptr_fetch: answers controller pointer requests with a registered struct
// (sample base, coefficient base, phase), tracking phase, ring head and credit.
// Optional feature macro: PTR_FETCH_OVF_DET_EN (credit saturation + overflow flag).
module ptr_fetch
  import ptr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned COEF_AW = DEF_COEF_AW,
  parameter int unsigned PHASES  = DEF_PHASES,
  parameter int unsigned TAPS    = DEF_TAPS,
  parameter int unsigned CRED_W  = DEF_CRED_W
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  ptr_fetch_if.slave bus
);

  localparam int unsigned PHASE_W = phase_w(PHASES);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);

  state_e             state_q;
  logic               req_complete_q;
  logic               iw_valid_q;
  logic               valid_q;
  logic               first_q;
  logic [ADDR_W-1:0]  smp_q;
  logic [COEF_AW-1:0] coef_q;
  logic [PHASE_W-1:0] phase_q;
  logic               last_q;

  logic [PHASE_W-1:0] phase_d;
  logic               need;
  logic               valid;
  logic               consume;
  logic [CRED_W-1:0]  cred_cnt;
  logic               cred_zero;
  logic               cred_ovf;

  // Next phase and validity of the struct under evaluation
  always_comb begin
    phase_d = '0;
    if (!first_q && phase_q != PHASE_LAST) phase_d = phase_q + PHASE_W'(1);
    need    = (phase_d == '0);
    valid   = !need || !cred_zero;
    consume = (state_q == ST_EVAL) && need && valid;
  end

  ptr_credit_cnt #(
    .CRED_W (CRED_W)
  ) u_cred (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .inc_i  (bus.new_in),
    .dec_i  (consume),
    .cnt_o  (cred_cnt),
    .zero_o (cred_zero),
    .ovf_o  (cred_ovf)
  );

  // Request FSM with registered response strobe and pointer struct
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_complete_q <= 1'b0;
      iw_valid_q     <= 1'b0;
      valid_q        <= 1'b0;
      first_q        <= 1'b1;
      smp_q          <= '0;
      coef_q         <= '0;
      phase_q        <= '0;
      last_q         <= 1'b0;
    end else if (en) begin
      req_complete_q <= 1'b0;
      iw_valid_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.ptrs_req) state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          valid_q <= valid;
          if (valid) begin
            first_q <= 1'b0;
            phase_q <= phase_d;
            last_q  <= (phase_d == PHASE_LAST);
            coef_q  <= need ? '0 : coef_q + COEF_AW'(TAPS);
            if (need) smp_q <= smp_q + ADDR_W'(1);
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          req_complete_q <= 1'b1;
          iw_valid_q     <= valid_q;
          state_q        <= valid_q ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (!bus.ptrs_req) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_complete = req_complete_q;
  assign bus.iw_valid     = iw_valid_q;
  assign bus.smp_base     = smp_q;
  assign bus.coef_base    = coef_q;
  assign bus.phase        = phase_q;
  assign bus.last_phase   = last_q;
  assign bus.ovf          = cred_ovf;

  logic unused_cnt;
  assign unused_cnt = ^cred_cnt;

endmodule

// File: tb/tb_ptr_fetch.sv
// Self-checking bench for ptr_fetch against a transaction-level reference model.
module tb_ptr_fetch;

  localparam int ADDR_W  = 8;
  localparam int COEF_AW = 10;
  localparam int PHASES  = 4;
  localparam int TAPS    = 16;
  localparam int CRED_W  = 4;
  localparam int PHASE_W = 2;
  localparam int CMAX    = (1 << CRED_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  ptr_fetch_if #(.ADDR_W(ADDR_W), .COEF_AW(COEF_AW), .PHASE_W(PHASE_W)) bus ();

  ptr_fetch #(
    .ADDR_W(ADDR_W), .COEF_AW(COEF_AW), .PHASES(PHASES), .TAPS(TAPS), .CRED_W(CRED_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: last issued struct and sample credit
  int m_credit, m_phase, m_smp;
  bit m_first, m_ovf;

  task automatic model_reset();
    m_credit = 0; m_phase = 0; m_smp = 0; m_first = 1'b1; m_ovf = 1'b0;
  endtask

  task automatic model_new_in();
`ifdef PTR_FETCH_OVF_DET_EN
    if (m_credit == CMAX) m_ovf = 1'b1;
    else m_credit = m_credit + 1;
`else
    m_credit = (m_credit + 1) % (CMAX + 1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.ptrs_req = 1'b0; bus.new_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse_new_in();
    @(negedge clk); bus.new_in = 1'b1;
    @(negedge clk); bus.new_in = 1'b0;
    model_new_in();
  endtask

  // One full request transaction; optionally a new_in pulse lands on the EVAL edge
  task automatic do_req(input string tag, input bit coin);
    int  pnext, lat;
    bit  need, valid, got;
    pnext = m_first ? 0 : (m_phase + 1) % PHASES;
    need  = (pnext == 0);
    valid = !need || (m_credit != 0);
    got = 1'b0; lat = 0;
    @(negedge clk); bus.ptrs_req = 1'b1;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(posedge clk); #1;
      bus.new_in = (k == 1) && coin;
      if (bus.req_complete === 1'b1) begin got = 1'b1; lat = k; end
    end
    if (valid) begin
      m_phase = pnext; m_first = 1'b0;
      if (need) begin m_smp = (m_smp + 1) % (1 << ADDR_W); m_credit = m_credit - 1; end
    end
    if (coin) model_new_in();
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL %s latency: got %0d expected 3", tag, lat); end
    n_vec++;
    if (bus.iw_valid !== valid) begin n_err++; $display("FAIL %s iw_valid: got %b expected %b", tag, bus.iw_valid, valid); end
    n_vec++;
    if (bus.phase !== PHASE_W'(m_phase)) begin n_err++; $display("FAIL %s phase: got %0d expected %0d", tag, bus.phase, m_phase); end
    n_vec++;
    if (bus.coef_base !== COEF_AW'(m_phase * TAPS)) begin n_err++; $display("FAIL %s coef_base: got %0d expected %0d", tag, bus.coef_base, m_phase * TAPS); end
    n_vec++;
    if (bus.smp_base !== ADDR_W'(m_smp)) begin n_err++; $display("FAIL %s smp_base: got %0d expected %0d", tag, bus.smp_base, m_smp); end
    n_vec++;
    if (bus.last_phase !== (m_phase == PHASES - 1)) begin n_err++; $display("FAIL %s last_phase: got %b expected %b", tag, bus.last_phase, m_phase == PHASES - 1); end
    @(negedge clk); bus.ptrs_req = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.req_complete !== 1'b0) begin n_err++; $display("FAIL %s strobe width: got %b expected 0", tag, bus.req_complete); end
    n_vec++;
    if (dut.u_cred.cnt_o !== CRED_W'(m_credit)) begin n_err++; $display("FAIL %s credit: got %0d expected %0d", tag, dut.u_cred.cnt_o, m_credit); end
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if ({bus.req_complete, bus.iw_valid, bus.last_phase, bus.ovf} !== 4'b0) begin
      n_err++; $display("FAIL reset flags: got %b expected 0000", {bus.req_complete, bus.iw_valid, bus.last_phase, bus.ovf});
    end
    n_vec++;
    if ({bus.smp_base, bus.coef_base, bus.phase} !== '0) begin
      n_err++; $display("FAIL reset struct: got %0d/%0d/%0d expected 0/0/0", bus.smp_base, bus.coef_base, bus.phase);
    end
    n_vec++;
    if (dut.u_cred.cnt_o !== '0) begin n_err++; $display("FAIL reset credit: got %0d expected 0", dut.u_cred.cnt_o); end
  endtask

  task automatic test_phase_sweep();
    do_reset();
    pulse_new_in();
    for (int i = 0; i < PHASES; i++) do_req($sformatf("sweep%0d", i), 1'b0);
  endtask

  task automatic test_starvation();
    int t [3];
    int np, nv;
    bit gotv;
    np = 0;
    @(negedge clk); bus.ptrs_req = 1'b1;
    for (int k = 1; k <= 30 && np < 3; k++) begin
      @(posedge clk); #1;
      if (bus.req_complete === 1'b1) begin
        t[np] = k; np++;
        n_vec++;
        if (bus.iw_valid !== 1'b0) begin n_err++; $display("FAIL starve iw_valid: got %b expected 0", bus.iw_valid); end
      end
    end
    n_vec++;
    if (np !== 3) begin n_err++; $display("FAIL starve pulses: got %0d expected 3", np); end
    else begin
      n_vec++;
      if ((t[1] - t[0]) !== 3 || (t[2] - t[1]) !== 3) begin
        n_err++; $display("FAIL starve period: got %0d,%0d expected 3,3", t[1] - t[0], t[2] - t[1]);
      end
    end
    pulse_new_in();
    gotv = 1'b0; nv = 0;
    for (int k = 1; k <= 15 && !gotv; k++) begin
      @(posedge clk); #1;
      if (bus.req_complete === 1'b1 && bus.iw_valid === 1'b1) gotv = 1'b1;
    end
    m_phase = 0; m_smp = (m_smp + 1) % (1 << ADDR_W); m_credit = m_credit - 1;
    n_vec++;
    if (!gotv) begin n_err++; $display("FAIL starve recover: got no valid response expected one"); end
    n_vec++;
    if (bus.phase !== '0 || bus.coef_base !== '0) begin n_err++; $display("FAIL starve recover struct: got %0d/%0d expected 0/0", bus.phase, bus.coef_base); end
    n_vec++;
    if (bus.smp_base !== ADDR_W'(m_smp)) begin n_err++; $display("FAIL starve smp_base: got %0d expected %0d", bus.smp_base, m_smp); end
    @(negedge clk); bus.ptrs_req = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_simultaneous();
    pulse_new_in();
    for (int i = 0; i < PHASES - 1; i++) do_req("simul_pre", 1'b0);
    do_req("simul_consume", 1'b1);
  endtask

  task automatic test_enable();
    int rc;
    rc = 0;
    @(negedge clk); en = 1'b0; bus.new_in = 1'b1; bus.ptrs_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.req_complete === 1'b1) rc++;
    end
    @(negedge clk); bus.new_in = 1'b0; bus.ptrs_req = 1'b0;
    @(negedge clk); en = 1'b1;
    n_vec++;
    if (rc !== 0) begin n_err++; $display("FAIL enable strobe: got %0d responses expected 0", rc); end
    n_vec++;
    if (dut.u_cred.cnt_o !== CRED_W'(m_credit)) begin n_err++; $display("FAIL enable credit: got %0d expected %0d", dut.u_cred.cnt_o, m_credit); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) if (m_credit < 12) pulse_new_in();
      do_req($sformatf("rand%0d", i), ($urandom_range(0, 3) == 0) && (m_credit < 12));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    @(negedge clk); bus.new_in = 1'b1;
    for (int i = 0; i < 16; i++) begin @(negedge clk); model_new_in(); end
    bus.new_in = 1'b0;
    #1;
    n_vec++;
    if (dut.u_cred.cnt_o !== CRED_W'(m_credit)) begin n_err++; $display("FAIL ovf credit: got %0d expected %0d", dut.u_cred.cnt_o, m_credit); end
    n_vec++;
    if (bus.ovf !== m_ovf) begin n_err++; $display("FAIL ovf flag: got %b expected %b", bus.ovf, m_ovf); end
    do_req("ovf_req", 1'b0);
    n_vec++;
    if (bus.ovf !== m_ovf) begin n_err++; $display("FAIL ovf sticky: got %b expected %b", bus.ovf, m_ovf); end
    do_reset();
    #1;
    n_vec++;
    if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf reset: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_reset_mid();
    int rc;
    rc = 0;
    do_reset();
    pulse_new_in();
    @(negedge clk); bus.ptrs_req = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0; bus.ptrs_req = 1'b0;
    @(posedge clk); #1;
    model_reset();
    n_vec++;
    if ({bus.req_complete, bus.iw_valid, bus.last_phase, bus.ovf} !== 4'b0) begin
      n_err++; $display("FAIL midreset flags: got %b expected 0000", {bus.req_complete, bus.iw_valid, bus.last_phase, bus.ovf});
    end
    n_vec++;
    if ({bus.smp_base, bus.coef_base, bus.phase} !== '0 || dut.u_cred.cnt_o !== '0) begin
      n_err++; $display("FAIL midreset state: got smp %0d coef %0d phase %0d credit %0d expected all 0",
                        bus.smp_base, bus.coef_base, bus.phase, dut.u_cred.cnt_o);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.req_complete === 1'b1) rc++;
    end
    n_vec++;
    if (rc !== 0) begin n_err++; $display("FAIL midreset dropped: got %0d responses expected 0", rc); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; bus.ptrs_req = 1'b0; bus.new_in = 1'b0;
    model_reset();
    test_reset();
    pulse_new_in();
    do_req("first", 1'b0);
    test_phase_sweep();
    test_starvation();
    test_simultaneous();
    test_enable();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
